alu_seq_exec: RTL

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

---
 rtl/alu_seq_exec.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts and a shift-add multiplier.
// One request in flight at a time; the result is held until the consumer takes it.
module alu_seq_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_operation,
    input  logic [5:0]         function_code,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    localparam int unsigned CntW = SHAMT_W + 1;
    localparam logic [CntW-1:0] MulIters = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {StIdle, StShift, StMul, StDone} state_e;
    typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpSll, OpSrl, OpMul} op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             left_q, left_d;
    logic             illegal_q, illegal_d;

    op_e              dec_op;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_res;

    // Undecodable encodings fall back to add and flag illegal.
    always_comb begin
        dec_op      = OpAdd;
        dec_illegal = 1'b0;
        case (alu_operation)
            3'b000, 3'b100: dec_op = OpAdd;
            3'b001:         dec_op = OpSub;
            3'b101:         dec_op = OpAnd;
            3'b111:         dec_op = OpOr;
            3'b010: begin
                case (function_code)
                    6'b100000: dec_op = OpAdd;
                    6'b100010: dec_op = OpSub;
                    6'b100100: dec_op = OpAnd;
                    6'b100101: dec_op = OpOr;
                    6'b101010: dec_op = OpSlt;
                    6'b000000: dec_op = OpSll;
                    6'b000001: dec_op = OpSrl;
                    6'b011000: dec_op = OpMul;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_res = op_a + op_b;
        case (dec_op)
            OpSub:   alu_res = op_a - op_b;
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpSlt:   alu_res = WIDTH'($signed(op_a) < $signed(op_b));
            default: alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        left_d    = left_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    illegal_d = dec_illegal;
                    case (dec_op)
                        OpSll, OpSrl: begin
                            result_d = op_a;
                            left_d   = (dec_op == OpSll);
                            count_d  = {1'b0, shamt};
                            state_d  = (shamt == '0) ? StDone : StShift;
                        end
                        OpMul: begin
                            result_d = '0;
                            mcand_d  = op_a;
                            mplier_d = op_b;
                            count_d  = MulIters;
                            state_d  = StMul;
                        end
                        default: begin
                            result_d = alu_res;
                            state_d  = StDone;
                        end
                    endcase
                end
            end
            StShift: begin
                result_d = left_q ? (result_q << 1) : (result_q >> 1);
                count_d  = count_q - CntOne;
                if (count_q == CntOne) state_d = StDone;
            end
            StMul: begin
                // Low WIDTH bits only; bits shifted out of mcand cannot reach the low half.
                if (mplier_q[0]) result_d = result_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CntOne;
                if (count_q == CntOne) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            left_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            left_q    <= left_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

endmodule
